cache_miss_ctrl: RTL
====================

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  ADDRESS_WIDTH, 32, byte address width.
  DATA_WIDTH, 32, CPU word width.
  LINE_BITS, 32, cache line width.
  OFFSET_BITS, 6, line offset field width; memory addresses have these bits zeroed.
  MAX_RETRY, 3, replay misses tolerated per request before error.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk, in, 1, clock.
  rst, in, 1, reset, asynchronous, active-high.
  cpu_req_valid, in, 1, CPU request present.
  cpu_req_ready, out, 1, controller accepts request.
  cpu_req_addr, in, ADDRESS_WIDTH, request address.
  cpu_req_we, in, 1, 1 = write.
  cpu_req_wdata, in, DATA_WIDTH, write data.
  cpu_resp_valid, out, 1, one-cycle response strobe.
  cpu_resp_data, out, DATA_WIDTH, read data, or echoed write data.
  cache_lookup, out, 1, cache access strobe.
  cache_addr, out, ADDRESS_WIDTH, latched request address.
  cache_we, out, 1, write enable; cache applies it only on hit.
  cache_wdata, out, DATA_WIDTH, latched write data.
  cache_hit, in, 1, combinational hit in the cache_lookup cycle.
  cache_rdata, in, DATA_WIDTH, combinational read data.
  cache_victim_dirty, in, 1, selected victim is valid and dirty.
  cache_victim_addr, in, ADDRESS_WIDTH, victim line address.
  cache_victim_line, in, LINE_BITS, victim line data.
  cache_fill, out, 1, one-cycle line install strobe.
  cache_fill_line, out, LINE_BITS, line to install.
  mem_req_valid, out, 1, memory request.
  mem_req_ready, in, 1, memory accepts request.
  mem_req_we, out, 1, 1 = writeback, 0 = refill.
  mem_req_addr, out, ADDRESS_WIDTH, line-aligned address.
  mem_req_wline, out, LINE_BITS, writeback data.
  mem_resp_valid, in, 1, write acknowledge, or refill data valid.
  mem_resp_line, in, LINE_BITS, refill data.
  busy, out, 1, controller not in IDLE.
  err, out, 1, sticky retry-overflow flag.
  hit_count, out, 16, saturating hit counter.
  miss_count, out, 16, saturating miss counter.

Function
REQ-003 The controller SHALL use states IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, FILL and RESP, all registered.
REQ-004 IDLE SHALL drive cpu_req_ready=1; on valid&ready the controller SHALL latch addr/we/wdata, clear the retry count and go to LOOKUP; cpu_req_ready SHALL be 0 in every other state.
REQ-005 LOOKUP SHALL last exactly one cycle with cache_lookup=1, cache_we=latched we and cache_addr/cache_wdata=latched values, and SHALL sample the cache_* inputs at the end of that cycle.
REQ-006 A LOOKUP hit SHALL register cpu_resp_data (cache_rdata for reads, latched wdata for writes) and go to RESP.
REQ-007 A LOOKUP miss SHALL latch victim addr/line and go to WB_REQ if cache_victim_dirty=1, else RF_REQ.
REQ-008 WB_REQ SHALL drive mem_req_valid=1, we=1, addr=victim addr, wline=victim line, all held stable until mem_req_ready=1, then go to WB_WAIT.
REQ-009 WB_WAIT SHALL wait for mem_resp_valid=1, then go to RF_REQ.
REQ-010 RF_REQ SHALL drive mem_req_valid=1, we=0, addr=latched address with OFFSET_BITS LSBs zeroed, held until mem_req_ready=1, then go to RF_WAIT.
REQ-011 RF_WAIT SHALL latch mem_resp_line on mem_resp_valid=1 and go to FILL.
REQ-012 FILL SHALL pulse cache_fill=1 for one cycle with cache_fill_line=latched line, then return to LOOKUP (replay), so that writes complete through the hit path.
REQ-013 A replay miss SHALL increment the retry count and repeat the miss path; when the count reaches MAX_RETRY the controller SHALL set err=1, drive cpu_resp_valid with cpu_resp_data=0 and return to IDLE.
REQ-014 RESP SHALL assert cpu_resp_valid for exactly one cycle, then go to IDLE.
REQ-015 mem_resp_valid SHALL be ignored outside WB_WAIT and RF_WAIT; mem_req_ready SHALL be ignored outside WB_REQ and RF_REQ.
REQ-016 hit_count SHALL increment once per request whose first LOOKUP hits; miss_count SHALL increment once per request whose first LOOKUP misses; replays SHALL never count; both SHALL saturate at 16'hFFFF.
REQ-017 Hit latency SHALL be: request accepted in cycle 0, LOOKUP in cycle 1, cpu_resp_valid in cycle 2.
REQ-018 A clean miss with mem_req_ready=1 and refill data k cycles after acceptance SHALL give cpu_resp_valid k+5 cycles after request acceptance.

Reset
REQ-019 While rst=1 the state SHALL be IDLE and all outputs 0 (cpu_req_ready, busy, err and both counters included); cpu_req_ready SHALL rise in the first cycle after release.
REQ-020 Reset mid-transaction SHALL abandon any outstanding memory request without completing it or issuing cache_fill.

Verification
REQ-021 Read hit at 0x100 with cache_rdata=0xDEADBEEF -> cpu_resp_valid in cycle 2, data 0xDEADBEEF, hit_count=1.
REQ-022 Clean read miss at 0x1234 -> RF_REQ addr 0x1200, we=0; refill line 0xA5A5A5A5 -> one cache_fill pulse, replay hit, response, miss_count=1, hit_count=0.
REQ-023 Dirty miss with victim 0x4000/0x11223344, mem_req_ready low 3 cycles -> writeback request held stable, then refill; order writeback before refill.
REQ-024 Replay misses MAX_RETRY times -> err=1, cpu_resp_valid with data 0, then IDLE with cpu_req_ready=1.
REQ-025 rst asserted during RF_WAIT, then a stray mem_resp_valid in IDLE -> no cache_fill, counters 0, state IDLE.
REQ-026 Preload hit_count to 16'hFFFF, issue one further hit -> hit_count stays 16'hFFFF.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Blocking miss controller between a CPU port, a single cache and memory.
// Misses write back a dirty victim, refill the line and replay the lookup.
module cache_miss_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LINE_BITS     = 32,
  parameter int OFFSET_BITS   = 6,
  parameter int MAX_RETRY     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req_valid,
  output logic                     cpu_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] cpu_req_addr,
  input  logic                     cpu_req_we,
  input  logic [DATA_WIDTH-1:0]    cpu_req_wdata,
  output logic                     cpu_resp_valid,
  output logic [DATA_WIDTH-1:0]    cpu_resp_data,
  output logic                     cache_lookup,
  output logic [ADDRESS_WIDTH-1:0] cache_addr,
  output logic                     cache_we,
  output logic [DATA_WIDTH-1:0]    cache_wdata,
  input  logic                     cache_hit,
  input  logic [DATA_WIDTH-1:0]    cache_rdata,
  input  logic                     cache_victim_dirty,
  input  logic [ADDRESS_WIDTH-1:0] cache_victim_addr,
  input  logic [LINE_BITS-1:0]     cache_victim_line,
  output logic                     cache_fill,
  output logic [LINE_BITS-1:0]     cache_fill_line,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
  output logic [LINE_BITS-1:0]     mem_req_wline,
  input  logic                     mem_resp_valid,
  input  logic [LINE_BITS-1:0]     mem_resp_line,
  output logic                     busy,
  output logic                     err,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_WAIT,
    RF_REQ, RF_WAIT, FILL, RESP
  } state_t;

  state_t state, state_next;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] vaddr_q;
  logic [LINE_BITS-1:0]     vline_q;
  logic [LINE_BITS-1:0]     line_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     we_q;
  logic                     replay_q;
  logic [RW-1:0]            retry_q;
  logic                     err_q;
  logic [15:0]              hit_q;
  logic [15:0]              miss_q;
  logic                     give_up;

  // Last permitted replay missed again: abandon the request with an error.
  assign give_up = (state == LOOKUP) && !cache_hit && replay_q &&
                   ((retry_q + RW'(1)) == RW'(MAX_RETRY));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-state output decode.
  always_comb begin
    state_next     = state;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cache_lookup   = 1'b0;
    cache_we       = 1'b0;
    cache_fill     = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wline  = '0;
    unique case (state)
      IDLE: begin
        cpu_req_ready = !rst;
        if (cpu_req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        cache_lookup = 1'b1;
        cache_we     = we_q;
        if (cache_hit || give_up)    state_next = RESP;
        else if (cache_victim_dirty) state_next = WB_REQ;
        else                         state_next = RF_REQ;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = vaddr_q;
        mem_req_wline = vline_q;
        if (mem_req_ready) state_next = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem_resp_valid) state_next = RF_REQ;
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[ADDRESS_WIDTH-1:OFFSET_BITS],
                         {OFFSET_BITS{1'b0}}};
        if (mem_req_ready) state_next = RF_WAIT;
      end
      RF_WAIT: begin
        if (mem_resp_valid) state_next = FILL;
      end
      FILL: begin
        cache_fill = 1'b1;
        state_next = LOOKUP;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request, victim, refill and response holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      vaddr_q  <= '0;
      vline_q  <= '0;
      line_q   <= '0;
      rdata_q  <= '0;
      replay_q <= 1'b0;
      retry_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && cpu_req_valid) begin
        addr_q   <= cpu_req_addr;
        we_q     <= cpu_req_we;
        wdata_q  <= cpu_req_wdata;
        replay_q <= 1'b0;
        retry_q  <= '0;
      end
      if (state == LOOKUP) begin
        if (cache_hit) begin
          rdata_q <= we_q ? wdata_q : cache_rdata;
        end else if (give_up) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          vaddr_q <= cache_victim_addr;
          vline_q <= cache_victim_line;
          if (replay_q) retry_q <= retry_q + RW'(1);
        end
      end
      if (state == RF_WAIT && mem_resp_valid) line_q <= mem_resp_line;
      if (state == FILL) replay_q <= 1'b1;
    end
  end

  // Saturating hit/miss counters, first lookup of a request only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == LOOKUP && !replay_q) begin
      if (cache_hit) begin
        if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
      end else begin
        if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
      end
    end
  end

  assign cache_addr      = addr_q;
  assign cache_wdata     = wdata_q;
  assign cache_fill_line = line_q;
  assign cpu_resp_data   = rdata_q;
  assign busy            = (state != IDLE);
  assign err             = err_q;
  assign hit_count       = hit_q;
  assign miss_count      = miss_q;

endmodule
